// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// mem_access_ctrl_pkg : shared encodings for the data-memory request sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam logic [ADDR_W-1:0] SP_RESET = 9'h1FF;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_PUSH  = 2'b10;
  localparam logic [1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_sp_unit.sv
// ============================================================================
// sp_unit : stack pointer register (grows down from SP_RESET) with full/empty
// Rev 1.0
// ============================================================================
`default_nettype none

module sp_unit
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 9'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_full,
  output logic              stack_empty
);

  // inc/dec are only ever raised when the full/empty guard allowed the op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= SP_RESET;
    end else if (inc) begin
      sp <= sp + 9'd1;
    end else if (dec) begin
      sp <= sp - 9'd1;
    end
  end

  assign stack_empty = (sp == SP_RESET);
  assign stack_full  = (sp == STACK_LIMIT - 9'd1);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : sequences one LOAD/STORE/PUSH/POP at a time into the data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                N           = 16,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 9'd256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N-1:0]      req_wdata,
  output logic              mem_WR,
  output logic              mem_RD,
  output logic              mem_psh,
  output logic              mem_pop,
  output logic [ADDR_W-1:0] mem_address,
  output logic [N-1:0]      mem_data_in,
  output logic [ADDR_W-1:0] stackpointer,
  input  logic [N-1:0]      mem_rdata,
  output logic              resp_valid,
  output logic [N-1:0]      resp_data,
  output logic              resp_err,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [N-1:0]        r_wdata;
  logic                r_err;
  logic [N-1:0]        r_resp_data;
  logic                r_ovf;
  logic                r_udf;
  logic                w_ovf;
  logic                w_udf;
  logic                w_accept;
  logic                w_sp_inc;
  logic                w_sp_dec;

  sp_unit #(.STACK_LIMIT(STACK_LIMIT)) u_sp (
    .clk         (clk),
    .rst         (rst),
    .inc         (w_sp_inc),
    .dec         (w_sp_dec),
    .sp          (stackpointer),
    .stack_full  (stack_full),
    .stack_empty (stack_empty)
  );

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_ovf    = (req_op == OP_PUSH) && stack_full;
  assign w_udf    = (req_op == OP_POP) && stack_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= OP_LOAD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_ovf || w_udf;
        // Rejected requests skip WAIT, so their zero response is loaded here
        if (w_ovf || w_udf) begin
          r_resp_data <= '0;
        end
        if (w_ovf) begin
          r_ovf <= 1'b1;
        end
        if (w_udf) begin
          r_udf <= 1'b1;
        end
      end
      if (r_state == ST_WAIT) begin
        r_resp_data <= ((r_op == OP_LOAD) || (r_op == OP_POP)) ? mem_rdata : '0;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_WR     = 1'b0;
    mem_RD     = 1'b0;
    mem_psh    = 1'b0;
    mem_pop    = 1'b0;
    w_sp_inc   = 1'b0;
    w_sp_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = (w_ovf || w_udf) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // SP moves on the same edge the memory samples, so it sees the old SP
        case (r_op)
          OP_LOAD:  mem_RD = 1'b1;
          OP_STORE: mem_WR = 1'b1;
          OP_PUSH: begin
            mem_psh  = 1'b1;
            w_sp_dec = 1'b1;
          end
          default: begin
            mem_pop  = 1'b1;
            w_sp_inc = 1'b1;
          end
        endcase
        w_next = ST_WAIT;
      end
      ST_WAIT: w_next = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign resp_data   = r_resp_data;
  assign resp_err    = r_err && resp_valid;
  assign ovf_sticky  = r_ovf;
  assign udf_sticky  = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : directed bench with a 512x16 registered-read memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        mem_WR, mem_RD, mem_psh, mem_pop;
  logic [8:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [8:0]  stackpointer;
  logic [15:0] mem_rdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        stack_full, stack_empty;
  logic        ovf_sticky, udf_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:511];

  always #5 clk = ~clk;

  mem_access_ctrl #(.N(16), .STACK_LIMIT(9'd509)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_WR       (mem_WR),
    .mem_RD       (mem_RD),
    .mem_psh      (mem_psh),
    .mem_pop      (mem_pop),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .stackpointer (stackpointer),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .ovf_sticky   (ovf_sticky),
    .udf_sticky   (udf_sticky)
  );

  // Data memory: writes and registered reads on the strobe's sampling edge
  always @(posedge clk) begin
    if (mem_WR)  mem[mem_address] <= mem_data_in;
    if (mem_psh) mem[stackpointer] <= mem_data_in;
    if (mem_RD)  mem_rdata <= mem[mem_address];
    if (mem_pop) mem_rdata <= mem[9'(stackpointer + 9'd1)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {mem_WR, mem_RD, mem_psh, mem_pop};
  endfunction

  // One request from IDLE; checks every cycle of the expected response window
  task automatic run_req(input string tag, input logic [1:0] op, input logic [8:0] addr,
                         input logic [15:0] wd, input logic err, input logic [15:0] exp_data,
                         input logic [8:0] sp_before, input logic [8:0] sp_after);
    logic [3:0] exp_strb;
    case (op)
      2'b00:   exp_strb = 4'b0100;
      2'b01:   exp_strb = 4'b1000;
      2'b10:   exp_strb = 4'b0010;
      default: exp_strb = 4'b0001;
    endcase
    @(negedge clk);
    chk({tag, "_ready_in"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (err) begin
      chk({tag, "_c1_strb"}, strobes(), 4'b0000);
      chk({tag, "_c1_valid"}, resp_valid, 1'b1);
      chk({tag, "_c1_err"}, resp_err, 1'b1);
      chk({tag, "_c1_data"}, resp_data, 16'h0000);
      chk({tag, "_c1_sp"}, stackpointer, sp_before);
      @(posedge clk); #1;
      chk({tag, "_c2_ready"}, req_ready, 1'b1);
      chk({tag, "_c2_valid"}, resp_valid, 1'b0);
      chk({tag, "_c2_sp"}, stackpointer, sp_after);
    end else begin
      chk({tag, "_c1_strb"}, strobes(), exp_strb);
      chk({tag, "_c1_sp"}, stackpointer, sp_before);
      chk({tag, "_c1_ready"}, req_ready, 1'b0);
      if (op == 2'b00 || op == 2'b01) chk({tag, "_c1_addr"}, mem_address, addr);
      if (op == 2'b01 || op == 2'b10) chk({tag, "_c1_wdata"}, mem_data_in, wd);
      @(posedge clk); #1;
      chk({tag, "_c2_strb"}, strobes(), 4'b0000);
      chk({tag, "_c2_sp"}, stackpointer, sp_after);
      chk({tag, "_c2_valid"}, resp_valid, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_c3_valid"}, resp_valid, 1'b1);
      chk({tag, "_c3_err"}, resp_err, 1'b0);
      chk({tag, "_c3_data"}, resp_data, exp_data);
      chk({tag, "_c3_ready"}, req_ready, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_c4_ready"}, req_ready, 1'b1);
      chk({tag, "_c4_valid"}, resp_valid, 1'b0);
    end
  endtask

  initial begin
    logic prev_acc;
    logic acc_now;
    int   n_acc;
    int   n_resp;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 9'd0; req_wdata = 16'h0000;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_sp", stackpointer, 9'h1FF);
    chk("rst_strb", strobes(), 4'b0000);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_data", resp_data, 16'h0000);
    chk("rst_sticky", {ovf_sticky, udf_sticky}, 2'b00);
    chk("rst_empty_full", {stack_empty, stack_full}, 2'b10);
    chk("rst_addr_wd", {mem_address, mem_data_in}, 25'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_req("store", 2'b01, 9'd5, 16'h1234, 1'b0, 16'h0000, 9'h1FF, 9'h1FF);
    run_req("load",  2'b00, 9'd5, 16'h0000, 1'b0, 16'h1234, 9'h1FF, 9'h1FF);

    run_req("udf", 2'b11, 9'd0, 16'h0000, 1'b1, 16'h0000, 9'h1FF, 9'h1FF);
    chk("udf_sticky", {ovf_sticky, udf_sticky}, 2'b01);

    run_req("push_a", 2'b10, 9'd0, 16'hAAAA, 1'b0, 16'h0000, 9'h1FF, 9'h1FE);
    run_req("push_b", 2'b10, 9'd0, 16'hBBBB, 1'b0, 16'h0000, 9'h1FE, 9'h1FD);
    run_req("pop_b",  2'b11, 9'd0, 16'h0000, 1'b0, 16'hBBBB, 9'h1FD, 9'h1FE);
    run_req("pop_a",  2'b11, 9'd0, 16'h0000, 1'b0, 16'hAAAA, 9'h1FE, 9'h1FF);
    chk("empty_again", stack_empty, 1'b1);

    run_req("push_1", 2'b10, 9'd0, 16'h1111, 1'b0, 16'h0000, 9'h1FF, 9'h1FE);
    run_req("push_2", 2'b10, 9'd0, 16'h2222, 1'b0, 16'h0000, 9'h1FE, 9'h1FD);
    chk("not_full_yet", stack_full, 1'b0);
    run_req("push_3", 2'b10, 9'd0, 16'h3333, 1'b0, 16'h0000, 9'h1FD, 9'h1FC);
    chk("full", stack_full, 1'b1);
    run_req("ovf", 2'b10, 9'd0, 16'h4444, 1'b1, 16'h0000, 9'h1FC, 9'h1FC);
    chk("ovf_sticky", {ovf_sticky, udf_sticky}, 2'b11);

    // Busy: req_valid held high; a strobe may appear only right after an accept
    req_valid = 1'b1; req_op = 2'b00; req_addr = 9'd5; req_wdata = 16'h0000;
    prev_acc = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc_now = req_valid && req_ready;
      chk("busy_strb", {3'b000, |strobes()}, {3'b000, prev_acc});
      prev_acc = acc_now;
      n_acc += int'(acc_now);
    end
    req_valid = 1'b0;
    chk("busy_accepts", n_acc, 3);
    @(posedge clk); #1;
    chk("busy_idle", req_ready, 1'b1);

    // Async reset in the WAIT cycle of a POP
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rpop_c1_pop", mem_pop, 1'b1);
    @(posedge clk); #1;
    chk("rpop_c2_sp", stackpointer, 9'h1FD);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 1'b1);
    chk("arst_sp", stackpointer, 9'h1FF);
    chk("arst_sticky", {ovf_sticky, udf_sticky}, 2'b00);
    chk("arst_valid", resp_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_resp += int'(resp_valid);
    end
    chk("arst_no_resp", n_resp, 0);
    chk("arst_ready_after", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
